// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the round-robin serial pattern scheduler.
package seq_detect_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } state_e;

  localparam logic [3:0] DefPattern = 4'b1101;

endpackage

// File: rtl/seq_detect_scheduler_if.sv
// Request/result bundle between NUM_CH requesters, the result consumer and the scheduler.
interface seq_detect_scheduler_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH*DATA_W-1:0] req_data;
  logic [NUM_CH-1:0]        req_ready;
  logic                     res_valid;
  logic                     res_ready;
  logic [CH_W-1:0]          res_ch;
  logic [CNT_W-1:0]         res_count;
  logic [CNT_W-1:0]         res_first;
  logic                     busy;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_ch, res_count, res_first, busy
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_ch, res_count, res_first, busy
  );

endinterface

// File: rtl/seq_match_core.sv
// Overlapping serial pattern matcher; hit is combinational on the bit being consumed.
module seq_match_core import seq_detect_pkg::*; #(
  parameter int unsigned         PAT_W   = 4,
  parameter logic [PAT_W-1:0]    PATTERN = DefPattern
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic bit_vld,
  input  logic bit_in,
  output logic hit
);

  localparam int unsigned FILL_W = $clog2(PAT_W);
  localparam logic [FILL_W-1:0] FillFull = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist_q;
  logic [FILL_W-1:0] fill_q;
  logic [PAT_W-1:0]  win;

  assign win = {hist_q, bit_in};
  // A hit needs PAT_W-1 real history bits, so no match can use cleared zeros.
  assign hit = bit_vld && (fill_q == FillFull) && (win == PATTERN);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      hist_q <= '0;
      fill_q <= '0;
    end else if (bit_vld) begin
      hist_q <= win[PAT_W-2:0];
      if (fill_q != FillFull) fill_q <= fill_q + FILL_W'(1);
    end
  end

endmodule

// File: rtl/seq_detect_scheduler.sv
// Round-robin arbiter sharing one serial pattern matcher among NUM_CH requesters.
module seq_detect_scheduler import seq_detect_pkg::*; #(
  parameter int unsigned      NUM_CH  = 4,
  parameter int unsigned      DATA_W  = 16,
  parameter int unsigned      PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = DefPattern
) (
  input logic                   clk,
  input logic                   rst,
  seq_detect_scheduler_if.slave bus
);

  localparam int unsigned CH_W  = $clog2(NUM_CH);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(DATA_W - 1);

  state_e             state_q;
  logic [CH_W-1:0]    last_grant_q;
  logic [CH_W-1:0]    ch_q;
  logic [DATA_W-1:0]  data_q;
  logic [CNT_W-1:0]   idx_q, count_q, first_q;
  logic               res_valid_q, busy_q;

  logic [NUM_CH-1:0]  grant_oh;
  logic [CH_W-1:0]    grant_ch;
  logic               grant_any;
  logic [DATA_W-1:0]  grant_word;
  logic               hit;

  // Search starts just after the last granted channel and wraps.
  always_comb begin
    int unsigned c;
    c         = 0;
    grant_oh  = '0;
    grant_ch  = '0;
    grant_any = 1'b0;
    for (int unsigned k = 1; k <= NUM_CH; k++) begin
      c = (32'(last_grant_q) + k) % NUM_CH;
      if (!grant_any && bus.req_valid[c]) begin
        grant_any   = 1'b1;
        grant_ch    = CH_W'(c);
        grant_oh[c] = 1'b1;
      end
    end
  end

  assign grant_word = bus.req_data[grant_ch*DATA_W +: DATA_W];

  seq_match_core #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_match (
    .clk     (clk),
    .rst     (rst),
    .clr     ((state_q == StIdle) && grant_any),
    .bit_vld (state_q == StShift),
    .bit_in  (data_q[DATA_W-1]),
    .hit     (hit)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_grant_q <= CH_W'(NUM_CH - 1);
      ch_q         <= '0;
      data_q       <= '0;
      idx_q        <= '0;
      count_q      <= '0;
      first_q      <= '0;
      res_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (grant_any) begin
            data_q       <= grant_word;
            ch_q         <= grant_ch;
            last_grant_q <= grant_ch;
            count_q      <= '0;
            first_q      <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b1;
            state_q      <= StShift;
          end
        end
        StShift: begin
          data_q <= data_q << 1;
          if (hit) begin
            count_q <= count_q + CNT_W'(1);
            if (count_q == '0) first_q <= idx_q;
          end
          if (idx_q == LastIdx) begin
            res_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            idx_q <= idx_q + CNT_W'(1);
          end
        end
        StDone: begin
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.req_ready = (state_q == StIdle) ? grant_oh : '0;
  assign bus.res_valid = res_valid_q;
  assign bus.res_ch    = ch_q;
  assign bus.res_count = count_q;
  assign bus.res_first = first_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_seq_detect_scheduler.sv
// Directed vector bench for seq_detect_scheduler with default parameters (PATTERN 1101).
module tb_seq_detect_scheduler;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned DATA_W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_detect_scheduler_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

  seq_detect_scheduler #(
    .NUM_CH (NUM_CH),
    .DATA_W (DATA_W),
    .PAT_W  (4),
    .PATTERN(4'b1101)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          ch;
    logic [15:0] data;
    int          count;
    int          first;
    int          hold;
  } vec_t;

  vec_t vecs[8];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.res_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Waits (bounded) for a grant to ch and returns after the accept edge.
  task automatic grant_and_accept(input int ch, output bit ok);
    int n = 0;
    ok = 1'b0;
    @(negedge clk);
    while (!bus.req_ready[ch] && n < 60) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("grant_onehot_ch%0d", ch), 32'(bus.req_ready), 32'(1) << ch);
    if (!bus.req_ready[ch]) return;
    step();
    bus.req_valid[ch] = 1'b0;
    ok = 1'b1;
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    int lat = 0;
    bit leak = 1'b0;
    bus.req_data[v.ch*DATA_W +: DATA_W] = v.data;
    bus.req_valid[v.ch] = 1'b1;
    grant_and_accept(v.ch, ok);
    if (!ok) return;
    while (!bus.res_valid && lat < 40) begin
      if (bus.req_ready != '0 || !bus.busy) leak = 1'b1;
      step();
      lat++;
    end
    check("result_latency", 32'(lat), 32'(DATA_W));
    check("ready_low_busy_high_in_shift", 32'(leak), 32'(0));
    check("res_ch", 32'(bus.res_ch), 32'(v.ch));
    check("res_count", 32'(bus.res_count), 32'(v.count));
    check("res_first", 32'(bus.res_first), 32'(v.first));
    for (int i = 0; i < v.hold; i++) begin
      step();
      check("hold_stable", {bus.res_valid, bus.req_ready, 3'b0, bus.res_ch,
                            bus.res_count, bus.res_first},
            {1'b1, 4'b0, 3'b0, 2'(v.ch), 5'(v.count), 5'(v.first)});
    end
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("idle_after_handshake", {bus.res_valid, bus.busy}, 32'(0));
  endtask

  initial begin
    bit          ok;
    int          order[$];
    int          n;
    bit          multi;
    bit          ch2_seen;
    int          exp_order[5] = '{0, 1, 2, 3, 0};

    vecs[0] = '{1, 16'hDB6D, 5,  3, 0};
    vecs[1] = '{0, 16'h0006, 0,  0, 0};
    vecs[2] = '{0, 16'h8000, 0,  0, 0};
    vecs[3] = '{2, 16'hD000, 1,  3, 5};
    vecs[4] = '{3, 16'hFFFF, 0,  0, 0};
    vecs[5] = '{0, 16'hDDDD, 4,  3, 0};
    vecs[6] = '{2, 16'h0DB6, 3,  7, 0};
    vecs[7] = '{1, 16'h000D, 1, 15, 2};

    bus.req_data = '0;
    do_reset();
    @(negedge clk);
    check("reset_outputs", {bus.req_ready, bus.res_valid, bus.busy, bus.res_ch,
                            bus.res_count, bus.res_first}, 32'(0));
    step();

    foreach (vecs[i]) run_vec(vecs[i]);

    // All channels held valid: strict rotation, one ready bit at a time.
    do_reset();
    for (int c = 0; c < NUM_CH; c++) bus.req_data[c*DATA_W +: DATA_W] = 16'hDB6D;
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    multi = 1'b0;
    n = 0;
    while (order.size() < 5 && n < 200) begin
      @(negedge clk);
      if ($countones(bus.req_ready) > 1) multi = 1'b1;
      for (int c = 0; c < NUM_CH; c++) if (bus.req_ready[c]) order.push_back(c);
      n++;
    end
    check("rr_grant_count", 32'(order.size()), 32'(5));
    check("rr_onehot", 32'(multi), 32'(0));
    for (int i = 0; i < 5; i++)
      if (i < order.size()) check($sformatf("rr_order_%0d", i), 32'(order[i]), 32'(exp_order[i]));

    // Reset in the middle of a scan discards the result and restores the pointer.
    do_reset();
    bus.req_data[1*DATA_W +: DATA_W] = 16'hDB6D;
    bus.req_valid[1] = 1'b1;
    grant_and_accept(1, ok);
    for (int i = 0; i < 8; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_reset_outputs", {bus.req_ready, bus.res_valid, bus.busy, bus.res_ch,
                                bus.res_count, bus.res_first}, 32'(0));
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (bus.res_valid || bus.busy) ok = 1'b1;
    end
    check("no_result_after_reset", 32'(ok), 32'(0));
    bus.req_valid[0] = 1'b1;
    bus.req_valid[2] = 1'b1;
    #1;
    check("post_reset_priority", 32'(bus.req_ready), 32'b0001);
    bus.req_valid = '0;

    // ch2 withdraws while the engine is busy; ch3 must win the next grant.
    bus.req_data[0*DATA_W +: DATA_W] = 16'h0000;
    bus.req_valid[0] = 1'b1;
    grant_and_accept(0, ok);
    bus.req_valid[2] = 1'b1;
    bus.req_valid[3] = 1'b1;
    ch2_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus.req_ready != '0) ch2_seen = 1'b1;
    end
    bus.req_valid[2] = 1'b0;
    bus.res_ready = 1'b1;
    grant_and_accept(3, ok);
    if (bus.req_ready[2]) ch2_seen = 1'b1;
    check("withdrawn_never_ready", 32'(ch2_seen), 32'(0));
    n = 0;
    while (!bus.res_valid && n < 40) begin
      if (bus.req_ready[2]) ch2_seen = 1'b1;
      step();
      n++;
    end
    check("ch3_result_ch", 32'(bus.res_ch), 32'(3));
    step();
    bus.res_ready = 1'b0;
    check("withdrawn_never_ready_end", {ch2_seen, bus.req_ready[2]}, 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
